// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Fetch front-end bus. Carries the redirect/stall controls,
//                the instruction-memory read port and the decoder-facing head
//                of the fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic              redirect;
    logic [31:0]       redirect_addr;
    logic              stall;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instruction;
    logic [31:0]       instruction_addr;
    logic [c_CW-1:0]   occupancy;

    // Fetch unit side: owns the memory request and the queue head.
    modport master (
        input  redirect, redirect_addr, stall, imem_rdata,
        output imem_req, imem_addr, instr_valid, instruction, instruction_addr, occupancy
    );

    // Environment side: pipeline control, instruction memory and decoder.
    modport slave (
        output redirect, redirect_addr, stall, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instruction, instruction_addr, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch front end. Owns the fetch PC, issues one
//                read per cycle to a 1-cycle synchronous instruction memory
//                and buffers returned words in a DEPTH-entry FIFO. Requests
//                are credited against queue space plus the read in flight so
//                a decoder stall never drops a response.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,     // asynchronous, active-low
    fetch_queue_if.master   bus
);
    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [31:0]     c_PC_MASK = 32'hFFFF_FFFC;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_inflight;
    logic            r_kill;
    logic [31:0]     r_data_mem [DEPTH];
    logic [31:0]     r_addr_mem [DEPTH];

    logic [c_CW-1:0] w_pending;
    logic            w_issue;
    logic            w_valid;
    logic            w_enq;
    logic            w_deq;

    // Credit check and queue handshakes; redirect overrides every queue action.
    always_comb begin
        w_pending = r_count + c_CW'(r_inflight);
        w_issue   = reset && !bus.redirect && (w_pending < c_DEPTH);
        w_valid   = (r_count != '0);
        w_enq     = r_inflight && !r_kill && !bus.redirect;
        w_deq     = w_valid && !bus.stall && !bus.redirect;
    end

    // Fetch PC, in-flight tracking, queue pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_resp_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end else if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_addr & c_PC_MASK;
            end

            if (bus.redirect) begin
                r_kill   <= r_inflight;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_kill <= 1'b0;
                if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage: instruction word with the PC it was fetched from.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_data_mem[r_wr_ptr] <= bus.imem_rdata;
            r_addr_mem[r_wr_ptr] <= r_resp_pc;
        end
    end

    // Memory request and combinational head-of-queue outputs.
    always_comb begin
        bus.imem_req         = w_issue;
        bus.imem_addr        = r_fetch_pc;
        bus.instr_valid      = w_valid;
        bus.instruction      = w_valid ? r_data_mem[r_rd_ptr] : 32'd0;
        bus.instruction_addr = w_valid ? r_addr_mem[r_rd_ptr] : 32'd0;
        bus.occupancy        = r_count;
    end

    // The request credit must keep a response from ever landing on a full queue.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        w_enq |-> (r_count != c_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed, table-driven bench for fetch_queue with a simple
//                instruction memory returning addr ^ 32'hA5A5_0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_XOR   = 32'hA5A5_0000;

    typedef struct {
        logic        redirect;
        logic [31:0] raddr;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_iaddr;
        int          exp_occ;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    fetch_queue_if #(.DEPTH(c_DEPTH)) bus ();

    fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (c_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory model: one-cycle synchronous read.
    always_ff @(posedge clock) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ c_XOR;
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [step %0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] iaddr, input int occ);
        logic [31:0] exp_instr;
        logic [31:0] exp_ia;
        exp_ia    = valid ? iaddr : 32'd0;
        exp_instr = valid ? (iaddr ^ c_XOR) : 32'd0;
        check("imem_req",         idx, {31'd0, bus.imem_req},    {31'd0, req});
        check("imem_addr",        idx, bus.imem_addr,            addr);
        check("instr_valid",      idx, {31'd0, bus.instr_valid}, {31'd0, valid});
        check("instruction_addr", idx, bus.instruction_addr,     exp_ia);
        check("instruction",      idx, bus.instruction,          exp_instr);
        check("occupancy",        idx, 32'(bus.occupancy),       32'(occ));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'd0;
        bus.stall         = 1'b0;

        //               redir raddr      stall req addr       valid iaddr      occ
        // Cold start and steady 1 instr/cycle
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h000, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h004, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h008, 1'b1, 32'h000, 1});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h00C, 1'b1, 32'h004, 1});
        // Stall: queue fills to DEPTH, requests stop, head holds
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h010, 1'b1, 32'h008, 1});
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h014, 1'b1, 32'h008, 2});
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b0, 32'h018, 1'b1, 32'h008, 3});
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b0, 32'h018, 1'b1, 32'h008, 4});
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b0, 32'h018, 1'b1, 32'h008, 4});
        // Drain in order
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b0, 32'h018, 1'b1, 32'h008, 4});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h018, 1'b1, 32'h00C, 3});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h01C, 1'b1, 32'h010, 2});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h020, 1'b1, 32'h014, 2});
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h024, 1'b1, 32'h018, 2});
        // Redirect with occupancy 3 and a read in flight
        vecs.push_back('{1'b1, 32'h100,   1'b0, 1'b0, 32'h028, 1'b1, 32'h018, 3});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h100, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h104, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1});
        // Redirect together with stall, unaligned target
        vecs.push_back('{1'b1, 32'h203,   1'b1, 1'b0, 32'h10C, 1'b1, 32'h104, 1});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h200, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h204, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h208, 1'b1, 32'h200, 1});
        // Back-to-back redirects: 0x40 then 0x80
        vecs.push_back('{1'b1, 32'h40,    1'b0, 1'b0, 32'h20C, 1'b1, 32'h204, 1});
        vecs.push_back('{1'b1, 32'h80,    1'b0, 1'b0, 32'h040, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h080, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h084, 1'b0, 32'h000, 0});
        vecs.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h088, 1'b1, 32'h080, 1});
        // Build occupancy 2 ahead of the mid-stream reset
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h08C, 1'b1, 32'h084, 1});
        vecs.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h090, 1'b1, 32'h084, 2});

        // Outputs held in reset
        repeat (3) @(posedge clock);
        #1;
        check_all(100, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin
                @(posedge clock);
                #1;
            end
            bus.redirect      = vecs[i].redirect;
            bus.redirect_addr = vecs[i].raddr;
            bus.stall         = vecs[i].stall;
            @(negedge clock);
            check_all(i, vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid,
                      vecs[i].exp_iaddr, vecs[i].exp_occ);
        end

        // Asynchronous reset mid-stream: outputs clear before any clock edge
        #2 reset = 1'b0;
        bus.stall = 1'b0;
        #1;
        check_all(200, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        @(posedge clock);
        #1;
        check_all(201, 1'b0, 32'h0, 1'b0, 32'h0, 0);

        // Restart from RESET_PC after release
        reset = 1'b1;
        @(negedge clock);
        check_all(202, 1'b1, 32'h000, 1'b0, 32'h000, 0);
        @(posedge clock);
        #1;
        check_all(203, 1'b1, 32'h004, 1'b0, 32'h000, 0);
        @(posedge clock);
        #1;
        check_all(204, 1'b1, 32'h008, 1'b1, 32'h000, 1);
        @(posedge clock);
        #1;
        check_all(205, 1'b1, 32'h00C, 1'b1, 32'h004, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
